formula_result_credit_buffer: RTL and testbench



---
 rtl/formula_pipe_pkg.sv | 12 +
 rtl/result_fifo_ff.sv | 65 ++++++
 rtl/formula_result_credit_buffer.sv | 87 ++++++++
 tb/tb_formula_result_credit_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/formula_pipe_pkg.sv
// rtl/formula_pipe_pkg.sv - shared types and width helpers for the formula pipeline result path
package formula_pipe_pkg;

    parameter int RES_W = 32;

    typedef logic [RES_W-1:0] res_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_fifo_ff.sv
// rtl/result_fifo_ff.sv - flip-flop result FIFO with occupancy count, any DEPTH >= 2
module result_fifo_ff
    import formula_pipe_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          read_data,
    output logic                      empty,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign read_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/formula_result_credit_buffer.sv
// rtl/formula_result_credit_buffer.sv - credit-gated result buffer behind the fixed-latency formula pipeline
// FORMULA_RESULT_BYPASS_EN: results arriving at an empty buffer are presented in the same cycle.
module formula_result_credit_buffer
    import formula_pipe_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_vld,
    output logic                      up_rdy,
    output logic                      arg_vld,
    input  logic                      res_vld,
    input  logic [WIDTH-1:0]          res,
    output logic                      down_vld,
    input  logic                      down_rdy,
    output logic [WIDTH-1:0]          down_data,
    output logic [cnt_w(DEPTH)-1:0]   occupancy,
    output logic                      err
);

    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0]    in_flight;
    logic [CW-1:0]    fifo_count;
    logic [WIDTH-1:0] head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             res_ok;
    logic             push;
    logic             pop;

    // Credits come from registered counts only, so up_rdy never waits on up_vld or down_rdy.
    assign occupancy = in_flight + fifo_count;
    assign up_rdy    = occupancy < CW'(DEPTH);
    assign arg_vld   = up_vld & up_rdy;
    assign res_ok    = res_vld & (in_flight != '0);

`ifdef FORMULA_RESULT_BYPASS_EN
    logic bypass;

    assign bypass    = fifo_empty & res_ok;
    assign down_vld  = ~fifo_empty | bypass;
    assign down_data = fifo_empty ? res : head;
    assign push      = res_ok & ~fifo_full & ~(bypass & down_rdy);
    assign pop       = ~fifo_empty & down_rdy;
`else
    assign down_vld  = ~fifo_empty;
    assign down_data = head;
    assign push      = res_ok & ~fifo_full;
    assign pop       = down_vld & down_rdy;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight <= '0;
            err       <= 1'b0;
        end else begin
            if (arg_vld && !res_ok) begin
                in_flight <= in_flight + CW'(1);
            end else if (res_ok && !arg_vld) begin
                in_flight <= in_flight - CW'(1);
            end
            // A result nobody asked for is dropped and flagged until the next reset.
            if (res_vld && in_flight == '0) begin
                err <= 1'b1;
            end
        end
    end

    result_fifo_ff #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (res),
        .pop       (pop),
        .read_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_formula_result_credit_buffer.sv
// tb/tb_formula_result_credit_buffer.sv - self-checking bench for formula_result_credit_buffer
module tb_formula_result_credit_buffer;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
`ifdef FORMULA_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             up_vld;
    logic             up_rdy;
    logic             arg_vld;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic             down_vld;
    logic             down_rdy;
    logic [WIDTH-1:0] down_data;
    logic [2:0]       occupancy;
    logic             err;

    always #5 clk = ~clk;

    formula_result_credit_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_vld    (up_vld),
        .up_rdy    (up_rdy),
        .arg_vld   (arg_vld),
        .res_vld   (res_vld),
        .res       (res),
        .down_vld  (down_vld),
        .down_rdy  (down_rdy),
        .down_data (down_data),
        .occupancy (occupancy),
        .err       (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Three-stage model pipeline: an argument accepted in cycle T returns as res_vld in T+3.
    logic        p_vld [3];
    logic [31:0] p_dat [3];
    bit          rand_mode;
    int          arg_k;

    // Reference model: outstanding credit count plus an ordered queue of buffered results.
    logic [31:0] mq [$];
    int          m_inf;
    bit          m_err;

    logic        s_rdy, s_arg, s_dv, s_err;
    logic [31:0] s_dat;
    logic [2:0]  s_occ;

    typedef struct {
        logic        up_vld;
        logic        down_rdy;
        logic        e_rdy;
        logic        e_arg;
        logic        e_dv;
        logic [31:0] e_dat;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit          e_rdy, e_arg, e_dv, byp;
        logic [31:0] e_dat;
        @(negedge clk);
        s_rdy = up_rdy;
        s_arg = arg_vld;
        s_dv  = down_vld;
        s_dat = down_data;
        s_occ = occupancy;
        s_err = err;

        byp   = BYP && mq.size() == 0 && res_vld && m_inf > 0;
        e_rdy = (m_inf + mq.size()) < DEPTH;
        e_arg = up_vld && e_rdy;
        e_dv  = mq.size() != 0 || byp;
        e_dat = (mq.size() != 0) ? mq[0] : res;

        check("up_rdy", 32'(s_rdy), 32'(e_rdy));
        check("arg_vld", 32'(s_arg), 32'(e_arg));
        check("down_vld", 32'(s_dv), 32'(e_dv));
        if (e_dv) check("down_data", s_dat, e_dat);
        check("occupancy", 32'(s_occ), 32'(m_inf + mq.size()));
        check("err", 32'(s_err), 32'(m_err));

        if (e_dv && down_rdy && mq.size() != 0) void'(mq.pop_front());
        if (res_vld) begin
            if (m_inf == 0) begin
                m_err = 1'b1;
            end else begin
                m_inf--;
                if (!(byp && down_rdy)) mq.push_back(res);
            end
        end
        if (e_arg) m_inf++;

        @(posedge clk);
        #1;
        p_vld[2] = p_vld[1];
        p_dat[2] = p_dat[1];
        p_vld[1] = p_vld[0];
        p_dat[1] = p_dat[0];
        p_vld[0] = s_arg;
        p_dat[0] = rand_mode ? $urandom : 32'h11 * (arg_k + 1);
        if (s_arg) arg_k++;
        res_vld = p_vld[2];
        res     = p_vld[2] ? p_dat[2] : 32'h0;
    endtask

    task automatic run(input int n, input bit uv, input bit dr);
        for (int i = 0; i < n; i++) begin
            up_vld   = uv;
            down_rdy = dr;
            step();
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd2};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, BYP, BYP ? 32'h11 : 32'h0, 3'd3};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3'd4};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3'd4};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3'd4};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 3'd4};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 3'd4};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 3'd3};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h33, 3'd2};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 3'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3'd0};

        for (int i = 0; i < 3; i++) begin
            p_vld[i] = 1'b0;
            p_dat[i] = 32'h0;
        end
        rst = 1'b0; up_vld = 1'b0; down_rdy = 1'b0; res_vld = 1'b0; res = 32'h0;
        rand_mode = 1'b0; arg_k = 0; m_inf = 0; m_err = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_up_rdy", 32'(up_rdy), 32'd1);
        check("rst_down_vld", 32'(down_vld), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        run(2, 1'b0, 1'b0);

        // Fill with consumer stalled, then drain in order.
        arg_k = 0;
        for (int i = 0; i < 13; i++) begin
            up_vld   = tbl[i].up_vld;
            down_rdy = tbl[i].down_rdy;
            step();
            check($sformatf("tbl%0d_up_rdy", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_arg_vld", i), 32'(s_arg), 32'(tbl[i].e_arg));
            check($sformatf("tbl%0d_down_vld", i), 32'(s_dv), 32'(tbl[i].e_dv));
            if (tbl[i].e_dv) check($sformatf("tbl%0d_down_data", i), s_dat, tbl[i].e_dat);
            check($sformatf("tbl%0d_occupancy", i), 32'(s_occ), 32'(tbl[i].e_occ));
        end

        rand_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            up_vld = 1'b1; down_rdy = 1'b1;
            step();
            check("occ_bound", 32'(s_occ <= 3'(DEPTH)), 32'd1);
        end
        run(8, 1'b0, 1'b1);

        // Unsolicited result with nothing in flight.
        res_vld = 1'b1;
        res     = 32'hdead_beef;
        run(1, 1'b0, 1'b1);
        run(3, 1'b0, 1'b1);
        check("err_sticky", 32'(s_err), 32'd1);
        check("err_no_push", 32'(s_occ), 32'd0);

        for (int i = 0; i < 200; i++) begin
            up_vld   = 1'($urandom_range(0, 1));
            down_rdy = 1'($urandom_range(0, 1));
            step();
        end

        // Reach two in flight and two buffered, then reset asynchronously mid-cycle.
        run(8, 1'b0, 1'b1);
        rand_mode = 1'b0;
        arg_k = 0;
        run(5, 1'b1, 1'b0);
        check("pre_rst_occupancy", 32'(occupancy), 32'd4);
        up_vld = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("async_up_rdy", 32'(up_rdy), 32'd1);
        check("async_arg_vld", 32'(arg_vld), 32'd0);
        check("async_down_vld", 32'(down_vld), 32'd0);
        check("async_occupancy", 32'(occupancy), 32'd0);
        check("async_err", 32'(err), 32'd0);
        mq.delete();
        m_inf = 0;
        m_err = 1'b0;
        #1 rst = 1'b1;
        run(4, 1'b0, 1'b1);
        check("stray_err", 32'(s_err), 32'd1);

        rand_mode = 1'b1;
        run(12, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            up_vld   = 1'($urandom_range(0, 1));
            down_rdy = 1'($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
